spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  SPI-mode-0 flash responder, the target end of the SoC SPI master's flash-read sequence.
//  Decodes the command byte and 24-bit address on MOSI, fetches 32-bit words from a backing
//  memory port, and streams the data bytes on MISO until SS deasserts.
//  Replaces the behavioural flash model with a synthesizable one for sim and FPGA. Single
//  clock domain: SCK is a registered output of the same clock.
// PARAMETERS
//  CMD_READ   8'h03  only command served; any other command is ignored
//  ADDR_BITS  24     address bits received after the command, MSB first
//  MISO_IDLE  1'b1   MISO level when not transmitting data
// PORTS
//  clock      in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  spi_sck    in   1   SPI clock from master, idle low (mode 0)
//  spi_ss     in   1   chip select, active low
//  spi_mosi   in   1   master-out serial data
//  spi_miso   out  1   slave-out serial data
//  mem_req    out  1   single-cycle read strobe to backing memory
//  mem_addr   out  22  word address: byte address [23:2]
//  mem_rdata  in   32  read data, valid exactly 1 cycle after mem_req; byte k = [8k+7:8k]
// BEHAVIOUR
//  Reset: spi_miso=MISO_IDLE, mem_req=0, mem_addr=0, state=IDLE. Reset mid-transfer aborts it.
//  Edges: sck_q <= spi_sck every cycle; rise = spi_sck & ~sck_q; fall = ~spi_sck & sck_q.
//   Requirement on master: SCK period >= 4 clocks (divider=1 case).
//  SS high, in any state: state->IDLE next cycle, miso=MISO_IDLE, bit counters cleared;
//   an outstanding mem response is dropped.
//  FSM, MOSI sampled on rise, MSB first:
//   IDLE: SS low -> CMD, bitcnt=0.
//   CMD: shift 8 bits. On 8th rise: ==CMD_READ -> ADDR, else -> IGNORE.
//   ADDR: shift ADDR_BITS. On last rise: latch addr; pulse mem_req next cycle with
//    mem_addr=addr[23:2], byte_off=addr[1:0] -> FETCH.
//   FETCH: cycle after mem_req, load word buffer from mem_rdata; drive bit 7 of byte
//    byte_off on miso the same cycle -> DATA. First data bit is stable >= 1 cycle before
//    the next rise.
//   DATA: on each rise, miso <= next bit, registered, valid the following cycle.
//    Bytes are MSB first, in ascending byte address order.
//    After bit 0 of byte 3: continue with byte 0 of the next word.
//   IGNORE: miso=MISO_IDLE, no mem_req, until SS high.
//  Prefetch: on the first rise inside byte 3 of the current word, pulse mem_req for
//   mem_addr+1. mem_addr wraps from 22'h3FFFFF to 0. Capture into a second buffer the
//   cycle after the pulse; swap buffers after the last bit of byte 3.
//  mem_req is never asserted twice in consecutive cycles. At most one request is
//   outstanding.
//  Falls are used only for assertions: MOSI/SS must not change on a rise cycle.
//  SS reasserted with no SCK edges in between: clean new transaction from CMD.
// STRUCTURE
//  spi_flash_pkg: state enum {IDLE,CMD,ADDR,FETCH,DATA,IGNORE}, CMD_READ default, SPI_MODE0 const.
//  Sub-module spi_sck_edge: sck_q register and rise/fall pulses, with the SS-high clear.
//  Top holds the FSM, shift-in register, 5-bit bitcnt, byte_off, two 32-bit word buffers
//   and a valid flag.
// TESTING  (mem model: mem[w] = {w[7:0]+3, w[7:0]+2, w[7:0]+1, w[7:0]} pattern unless stated)
//  1 cmd 03 addr 000004, mem[1]=32'h44332211, 32 data clocks -> MISO 11 22 33 44;
//    one mem_req, mem_addr=1.
//  2 cmd 03 addr 000006, 32 data clocks -> bytes from mem[1][23:16], mem[1][31:24], then mem[2] bytes 0,1;
//    prefetch of addr 2 issued before the byte boundary.
//  3 cmd 03 addr FFFFFC, 64 data clocks -> mem_addr 3FFFFF then 000000; stream continuous, no gap bit.
//  4 cmd C0 + 24 addr clocks + 32 clocks -> MISO constantly 1, mem_req never asserted.
//  5 SS high after 12 addr bits, then full read of addr 000008 -> first request mem_addr=2,
//    correct data returned.
//  6 reset asserted mid-DATA -> next cycle miso=1, mem_req=0, state IDLE; a following read succeeds.

Source files
------------

// File: rtl/spi_flash_responder_pkg.sv
// Shared constants for the SPI flash responder.
// Holds the served command, the address width, the MISO idle level, the SPI mode
// and the FSM state encodings, plus a bit-index helper for the word buffers.
package spi_flash_responder_pkg;

  localparam logic [7:0]  CmdRead      = 8'h03;
  localparam int unsigned AddrBits     = 24;
  localparam int unsigned WordAddrBits = AddrBits - 2;
  localparam logic        MisoIdle     = 1'b1;
  // {cpol, cpha}; mode 0 idles SCK low and samples on the rising edge
  localparam logic [1:0]  SpiMode0     = 2'b00;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCmd    = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StFetch  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
  localparam logic [2:0] StIgnore = 3'd5;

  // Bit position in a 32-bit word of byte byte_sel, transmit slot pos (slot 0 = bit 7).
  function automatic logic [4:0] bit_index(input logic [1:0] byte_sel, input logic [2:0] pos);
    return {byte_sel, ~pos};
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI and backing-memory signals of the flash responder.
//  spi_sck/spi_ss/spi_mosi : SPI master to responder
//  spi_miso                : responder to SPI master
//  mem_req/mem_addr        : responder read strobe and word address to memory
//  mem_rdata               : memory read data, valid the cycle after mem_req
interface spi_flash_responder_if;
  import spi_flash_responder_pkg::*;

  logic                    spi_sck;
  logic                    spi_ss;
  logic                    spi_mosi;
  logic                    spi_miso;
  logic                    mem_req;
  logic [WordAddrBits-1:0] mem_addr;
  logic [31:0]             mem_rdata;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_rdata,
    output spi_miso, mem_req, mem_addr
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_rdata,
    input  spi_miso, mem_req, mem_addr
  );

endinterface

// File: rtl/spi_flash_responder_sck_edge.sv
// SCK edge detector. Registers SCK and produces single-cycle rise/fall pulses.
// While SS is high the history register is held at the idle level and no edges
// are reported, so a new selection always starts from a clean idle SCK.
//  clock, reset : system clock, synchronous active-high reset
//  spi_sck      : SPI clock from master
//  spi_ss       : chip select, active low
//  rise, fall   : edge pulses, valid in the cycle SCK is first seen at its new level
module spi_flash_responder_sck_edge
  import spi_flash_responder_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  output logic rise,
  output logic fall
);

  logic sck_q;

  always_ff @(posedge clock) begin
    if (reset || spi_ss) begin
      sck_q <= SpiMode0[1];
    end else begin
      sck_q <= spi_sck;
    end
  end

  assign rise = ~spi_ss &  spi_sck & ~sck_q;
  assign fall = ~spi_ss & ~spi_sck &  sck_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ (0x03) from a 32-bit backing memory.
// Shifts in command and 24-bit address on SCK rises, fetches the addressed word,
// then streams bytes MSB first in ascending address order until SS deasserts,
// prefetching the following word while the last byte of the current one goes out.
//  clock, reset : system clock, synchronous active-high reset
//  bus (slave)  : SPI pins and backing-memory request/response
module spi_flash_responder
  import spi_flash_responder_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  spi_flash_responder_if.slave        bus
);

  logic rise, fall;

  spi_flash_responder_sck_edge u_sck_edge (
    .clock   (clock),
    .reset   (reset),
    .spi_sck (bus.spi_sck),
    .spi_ss  (bus.spi_ss),
    .rise    (rise),
    .fall    (fall)
  );

  logic [2:0]              state_q, state_d;
  logic [AddrBits-2:0]     shift_q, shift_d;
  logic [4:0]              bitcnt_q, bitcnt_d;
  logic [1:0]              byte_off_q, byte_off_d;
  logic [31:0]             word_q, word_d;
  logic [31:0]             next_q, next_d;
  logic                    next_valid_q, next_valid_d;
  logic                    miso_q, miso_d;
  logic                    mem_req_q, mem_req_d;
  logic [WordAddrBits-1:0] mem_addr_q, mem_addr_d;
  logic                    rsp_due_q, rsp_due_d;
  logic [AddrBits-1:0]     addr_in;

  assign addr_in = {shift_q, bus.spi_mosi};

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    byte_off_d   = byte_off_q;
    word_d       = word_q;
    next_d       = next_q;
    next_valid_d = next_valid_q;
    miso_d       = miso_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    rsp_due_d    = mem_req_q;

    if (bus.spi_ss) begin
      // Deselect aborts everything; a response still in flight is ignored.
      state_d      = StIdle;
      miso_d       = MisoIdle;
      bitcnt_d     = '0;
      rsp_due_d    = 1'b0;
      next_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StCmd;
          bitcnt_d = '0;
        end
        StCmd: if (rise) begin
          shift_d  = {shift_q[AddrBits-3:0], bus.spi_mosi};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = '0;
            state_d  = ({shift_q[6:0], bus.spi_mosi} == CmdRead) ? StAddr : StIgnore;
          end
        end
        StAddr: if (rise) begin
          shift_d  = {shift_q[AddrBits-3:0], bus.spi_mosi};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'(AddrBits - 1)) begin
            bitcnt_d   = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_in[AddrBits-1:2];
            byte_off_d = addr_in[1:0];
            state_d    = StFetch;
          end
        end
        StFetch: if (rsp_due_q) begin
          word_d   = bus.mem_rdata;
          miso_d   = bus.mem_rdata[bit_index(byte_off_q, 3'd0)];
          bitcnt_d = '0;
          state_d  = StData;
        end
        StData: begin
          if (rsp_due_q) begin
            next_d       = bus.mem_rdata;
            next_valid_d = 1'b1;
          end
          if (rise) begin
            // bitcnt[2:0] is the slot currently on MISO, which the master just sampled
            if (bitcnt_q[2:0] != 3'd7) begin
              bitcnt_d = bitcnt_q + 5'd1;
              miso_d   = word_q[bit_index(byte_off_q, bitcnt_q[2:0] + 3'd1)];
            end else begin
              bitcnt_d   = '0;
              byte_off_d = byte_off_q + 2'd1;
              if (byte_off_q == 2'd3) begin
                word_d       = next_q;
                next_valid_d = 1'b0;
                miso_d       = next_q[7];
              end else begin
                miso_d = word_q[bit_index(byte_off_q + 2'd1, 3'd0)];
              end
            end
            // Prefetch once per word, on the first rise inside byte 3.
            if (byte_off_q == 2'd3 && bitcnt_q[2:0] == 3'd0) begin
              mem_req_d  = 1'b1;
              mem_addr_d = mem_addr_q + 22'd1;
            end
          end
        end
        StIgnore: miso_d = MisoIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      byte_off_q   <= '0;
      word_q       <= '0;
      next_q       <= '0;
      next_valid_q <= 1'b0;
      miso_q       <= MisoIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      rsp_due_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      byte_off_q   <= byte_off_d;
      word_q       <= word_d;
      next_q       <= next_d;
      next_valid_q <= next_valid_d;
      miso_q       <= miso_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      rsp_due_q    <= rsp_due_d;
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  a_req_gap: assert property (@(posedge clock) disable iff (reset)
    mem_req_q |=> !mem_req_q);
  a_mosi_stable: assert property (@(posedge clock) disable iff (reset)
    rise |-> $stable(bus.spi_mosi));
  a_ss_stable: assert property (@(posedge clock) disable iff (reset)
    (rise || fall) |-> $stable(bus.spi_ss));
  a_next_ready: assert property (@(posedge clock) disable iff (reset)
    (state_q == StData && rise && bitcnt_q[2:0] == 3'd7 && byte_off_q == 2'd3)
      |-> next_valid_q);

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
  import spi_flash_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [21:0] req_log[$];

  always #5 clock = ~clock;

  spi_flash_responder_if bus ();

  spi_flash_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [21:0] w);
    logic [7:0] b;
    b = w[7:0];
    if (w == 22'd1) return 32'h44332211;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Memory model: data valid the cycle after the request.
  always @(posedge clock) begin
    if (bus.mem_req) bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  // Request logger, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset && bus.mem_req) req_log.push_back(bus.mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One SCK period of 4 clocks; MISO sampled as SCK rises.
  task automatic xfer_bit(input logic mo, output logic mi);
    @(negedge clock);
    bus.spi_mosi = mo;
    @(negedge clock);
    mi = bus.spi_miso;
    bus.spi_sck = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.spi_sck = 1'b0;
  endtask

  task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr, input int abits);
    logic b;
    bus.spi_ss = 1'b0;
    @(negedge clock);
    for (int i = 7; i >= 0; i--) xfer_bit(cmd[i], b);
    for (int i = 23; i > 23 - abits; i--) xfer_bit(addr[i], b);
  endtask

  task automatic read_bits(input int n, output logic [63:0] data);
    logic b;
    data = '0;
    for (int i = 0; i < n; i++) begin
      xfer_bit(1'b0, b);
      data = {data[62:0], b};
    end
  endtask

  task automatic end_txn();
    @(negedge clock);
    bus.spi_ss = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] d;
    int base;
    bus.spi_sck = 1'b0;
    bus.spi_ss = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_miso", 64'(bus.spi_miso), 64'd1);
    check("reset_req", 64'(bus.mem_req), 64'd0);
    check("reset_addr", 64'(bus.mem_addr), 64'd0);

    // 1: addr 000004
    base = req_log.size();
    start_txn(8'h03, 24'h000004, 24);
    read_bits(24, d);
    check("t1_bytes012", d, 64'h112233);
    check("t1_req_count_pre", 64'(req_log.size()), 64'(base + 1));
    check("t1_req_addr", 64'(req_log[base]), 64'd1);
    read_bits(8, d);
    check("t1_byte3", d, 64'h44);
    check("t1_prefetch_addr", 64'(req_log[base + 1]), 64'd2);
    end_txn();
    check("t1_miso_idle", 64'(bus.spi_miso), 64'd1);
    check("t1_state_idle", 64'(dut.state_q), 64'(StIdle));

    // 2: addr 000006, prefetch before word boundary
    base = req_log.size();
    start_txn(8'h03, 24'h000006, 24);
    read_bits(16, d);
    check("t2_first", d, 64'h3344);
    check("t2_prefetch_count", 64'(req_log.size()), 64'(base + 2));
    check("t2_prefetch_addr", 64'(req_log[base + 1]), 64'd2);
    read_bits(16, d);
    check("t2_second", d, 64'h0203);
    end_txn();

    // 3: wrap of word address
    base = req_log.size();
    start_txn(8'h03, 24'hFFFFFC, 24);
    read_bits(64, d);
    check("t3_stream", d, 64'hFF000102_00010203);
    check("t3_req0", 64'(req_log[base]), 64'h3FFFFF);
    check("t3_req1", 64'(req_log[base + 1]), 64'h0);
    end_txn();

    // 4: unknown command ignored
    base = req_log.size();
    start_txn(8'hC0, 24'h000000, 24);
    read_bits(32, d);
    check("t4_miso_ones", d, 64'hFFFFFFFF);
    check("t4_no_req", 64'(req_log.size()), 64'(base));
    end_txn();

    // 5: abort after 12 address bits, then a full read
    base = req_log.size();
    start_txn(8'h03, 24'h000008, 12);
    end_txn();
    check("t5_abort_no_req", 64'(req_log.size()), 64'(base));
    check("t5_abort_idle", 64'(dut.state_q), 64'(StIdle));
    start_txn(8'h03, 24'h000008, 24);
    read_bits(32, d);
    check("t5_data", d, 64'h02030405);
    check("t5_req_addr", 64'(req_log[base]), 64'd2);
    end_txn();

    // 6: reset mid-DATA, then a clean read
    start_txn(8'h03, 24'h000010, 24);
    read_bits(12, d);
    check("t6_partial", d, 64'h040);
    check("t6_addr_pre", 64'(bus.mem_addr), 64'd4);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_miso", 64'(bus.spi_miso), 64'd1);
    check("t6_rst_req", 64'(bus.mem_req), 64'd0);
    check("t6_rst_addr", 64'(bus.mem_addr), 64'd0);
    check("t6_rst_state", 64'(dut.state_q), 64'(StIdle));
    reset = 1'b0;
    end_txn();
    base = req_log.size();
    start_txn(8'h03, 24'h000004, 24);
    read_bits(32, d);
    check("t6_after_data", d, 64'h11223344);
    check("t6_after_req", 64'(req_log[base]), 64'd1);
    end_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
